// File: rtl/tlb_search_responder_pkg.sv
// Shared types for the TLB search responder slice.
// Request/response bundles, TLB entry layout and FSM encoding.
package tlb_search_responder_pkg;

  localparam int TLB_IDX_W = 5;
  localparam logic [5:0] PS_4K = 6'd12;

  typedef struct packed {
    logic [18:0] vppn;
    logic        odd;
    logic [9:0]  asid;
  } tlb_s_req_t;

  typedef struct packed {
    logic                 dmw;
    logic                 found;
    logic [TLB_IDX_W-1:0] index;
    logic [5:0]           ps;
    logic [19:0]          ppn;
    logic                 v;
    logic                 d;
    logic [1:0]           mat;
    logic [1:0]           plv;
  } tlb_s_resp_t;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/tlb_search_responder_match.sv
// One TLB entry against one search request.
// Produces the hit bit, the huge-page flag and the selected half-page.
module tlb_match_unit
  import tlb_search_responder_pkg::*;
#(
  parameter int PS_HUGE = 21
) (
  input  tlb_entry_t entry,
  input  tlb_s_req_t req,
  output logic       match,
  output logic       huge,
  output tlb_page_t  page
);

  logic vppn_eq;
  logic asid_ok;
  logic sel_odd;

  assign huge = (entry.ps == 6'(PS_HUGE));

  // Huge pages ignore vppn[8:0]; vppn[8] picks the half instead of odd
  assign vppn_eq = huge
    ? (entry.vppn[18:9] == req.vppn[18:9])
    : (entry.vppn == req.vppn);

  assign asid_ok = entry.g | (entry.asid == req.asid);
  assign match   = entry.e & asid_ok & vppn_eq;
  assign sel_odd = huge ? req.vppn[8] : req.odd;
  assign page    = sel_odd ? entry.p1 : entry.p0;

endmodule

// File: rtl/tlb_search_responder.sv
// Fully-associative TLB array answering search requests
// with a fixed IDLE->CMP->RESP lookup; accepts writes and invalidates.
module tlb_search_responder
  import tlb_search_responder_pkg::*;
#(
  parameter int ENTRY_NUM = 32,
  parameter int PS_HUGE   = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tlb_req_valid_i,
  input  tlb_s_req_t           tlb_req_i,
  output logic                 tlb_req_ready_o,
  output tlb_s_resp_t          tlb_resp_o,
  input  logic                 flush_i,
  input  logic                 we_i,
  input  logic [TLB_IDX_W-1:0] w_index_i,
  input  tlb_entry_t           w_entry_i,
  input  logic                 inv_all_i,
  input  logic [TLB_IDX_W-1:0] r_index_i,
  output tlb_entry_t           r_entry_o,
  output logic                 busy_o
);

  localparam int IW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  state_t      state_q, state_d;
  tlb_entry_t  tlb_q [ENTRY_NUM];
  tlb_s_req_t  req_q;
  tlb_s_resp_t resp_q, resp_d;
  logic        ready_q;

  logic [ENTRY_NUM-1:0] match_c, match_q;
  logic [ENTRY_NUM-1:0] huge_c;
  tlb_page_t            page_c [ENTRY_NUM];

  logic                 upd;
  logic                 accept;
  logic                 match_load;
  logic                 resp_load;
  logic                 hit;
  logic [TLB_IDX_W-1:0] hit_idx;

  assign upd = we_i | inv_all_i;

  // Array: invalidate-all lands first so a same-cycle write keeps its e
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++)
        tlb_q[i] <= '0;
    end else begin
      if (inv_all_i)
        for (int i = 0; i < ENTRY_NUM; i++)
          tlb_q[i].e <= 1'b0;
      if (we_i)
        tlb_q[w_index_i[IW-1:0]] <= w_entry_i;
    end
  end

  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_match
    tlb_match_unit #(
      .PS_HUGE (PS_HUGE)
    ) u_match (
      .entry (tlb_q[g]),
      .req   (req_q),
      .match (match_c[g]),
      .huge  (huge_c[g]),
      .page  (page_c[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Any array update during a search restarts the compare
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (tlb_req_valid_i && !flush_i) state_d = S_CMP;
      S_CMP: begin
        if (flush_i)  state_d = S_IDLE;
        else if (upd) state_d = S_CMP;
        else          state_d = S_RESP;
      end
      S_RESP: begin
        if (flush_i)  state_d = S_IDLE;
        else if (upd) state_d = S_CMP;
        else          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        hit     = 1'b1;
        hit_idx = TLB_IDX_W'(i);
      end
    end
  end

  always_comb begin
    accept     = (state_q == S_IDLE) & tlb_req_valid_i & ~flush_i;
    match_load = (state_q == S_CMP) & ~flush_i & ~upd;
    resp_load  = (state_q == S_RESP) & ~flush_i & ~upd;
    resp_d     = '0;
    if (hit) begin
      resp_d.found = 1'b1;
      resp_d.index = hit_idx;
      resp_d.ps    = huge_c[hit_idx[IW-1:0]] ? 6'(PS_HUGE) : PS_4K;
      resp_d.ppn   = page_c[hit_idx[IW-1:0]].ppn;
      resp_d.v     = page_c[hit_idx[IW-1:0]].v;
      resp_d.d     = page_c[hit_idx[IW-1:0]].d;
      resp_d.mat   = page_c[hit_idx[IW-1:0]].mat;
      resp_d.plv   = page_c[hit_idx[IW-1:0]].plv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      match_q <= '0;
      resp_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= resp_load;
      if (accept)     req_q   <= tlb_req_i;
      if (match_load) match_q <= match_c;
      if (resp_load)  resp_q  <= resp_d;
    end
  end

  assign tlb_req_ready_o = ready_q;
  assign tlb_resp_o      = resp_q;
  assign r_entry_o       = tlb_q[r_index_i[IW-1:0]];
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_tlb_search_responder.sv
// Directed bench for tlb_search_responder.
// Hand-built entries and expected responses, immediate assertions.
module tb_tlb_search_responder;
  import tlb_search_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  tlb_s_req_t  req;
  logic        ready;
  tlb_s_resp_t resp;
  logic        flush;
  logic        we;
  logic [4:0]  w_index;
  tlb_entry_t  w_entry;
  logic        inv_all;
  logic [4:0]  r_index;
  tlb_entry_t  r_entry;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_search_responder #(
    .ENTRY_NUM (32),
    .PS_HUGE   (21)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tlb_req_valid_i (valid),
    .tlb_req_i       (req),
    .tlb_req_ready_o (ready),
    .tlb_resp_o      (resp),
    .flush_i         (flush),
    .we_i            (we),
    .w_index_i       (w_index),
    .w_entry_i       (w_entry),
    .inv_all_i       (inv_all),
    .r_index_i       (r_index),
    .r_entry_o       (r_entry),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic tlb_entry_t mk(input logic [18:0] vppn,
    input logic [5:0] ps, input logic g, input logic [9:0] asid,
    input logic [19:0] ppn0, input logic [19:0] ppn1);
    tlb_entry_t t;
    t      = '0;
    t.e    = 1'b1;
    t.vppn = vppn;
    t.ps   = ps;
    t.g    = g;
    t.asid = asid;
    t.p0   = '{ppn: ppn0, plv: 2'd0, mat: 2'd1, d: 1'b1, v: 1'b1};
    t.p1   = '{ppn: ppn1, plv: 2'd3, mat: 2'd2, d: 1'b0, v: 1'b1};
    return t;
  endfunction

  function automatic tlb_s_resp_t hit_resp(input int idx,
    input logic [5:0] ps, input tlb_page_t p);
    tlb_s_resp_t r;
    r       = '0;
    r.found = 1'b1;
    r.index = 5'(idx);
    r.ps    = ps;
    r.ppn   = p.ppn;
    r.v     = p.v;
    r.d     = p.d;
    r.mat   = p.mat;
    r.plv   = p.plv;
    return r;
  endfunction

  function automatic tlb_s_req_t mkreq(input logic [18:0] vppn,
    input logic odd, input logic [9:0] asid);
    tlb_s_req_t q;
    q.vppn = vppn;
    q.odd  = odd;
    q.asid = asid;
    return q;
  endfunction

  task automatic write_entry(input int idx, input tlb_entry_t ent);
    we      = 1'b1;
    w_index = 5'(idx);
    w_entry = ent;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Issues a request; optionally writes an entry in cycle wr_cyc after issue
  task automatic search(input tlb_s_req_t rq, input int wr_cyc,
    input int wr_idx, input tlb_entry_t wr_ent,
    output int lat, output tlb_s_resp_t rs);
    lat   = -1;
    rs    = '0;
    req   = rq;
    valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      we = 1'b0;
      if (ready) begin
        lat   = c;
        rs    = resp;
        valid = 1'b0;
        break;
      end
      if (c == wr_cyc) begin
        we      = 1'b1;
        w_index = 5'(wr_idx);
        w_entry = wr_ent;
      end
    end
    valid = 1'b0;
    we    = 1'b0;
  endtask

  tlb_entry_t  e3, e3g, e7, e2, e9, e4, e4b;
  tlb_s_resp_t rs, exp_r, last_r;
  int          lat;
  int          seen;

  initial begin
    rst_n   = 1'b0;
    valid   = 1'b0;
    req     = '0;
    flush   = 1'b0;
    we      = 1'b0;
    w_index = '0;
    w_entry = '0;
    inv_all = 1'b0;
    r_index = '0;

    #1;
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_resp", 128'(resp), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_entry", 128'(r_entry), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic hit on the odd half
    e3 = mk(19'h12345, 6'd12, 1'b0, 10'd5, 20'h11111, 20'hABCDE);
    write_entry(3, e3);
    r_index = 5'd3;
    #1;
    chk("rd_idx3", 128'(r_entry), 128'(e3));
    search(mkreq(19'h12345, 1'b1, 10'd5), 0, 0, '0, lat, rs);
    chk("t1_lat", 128'(lat), 128'(3));
    chk("t1_resp", 128'(rs), 128'(hit_resp(3, 6'd12, e3.p1)));

    // asid mismatch misses, global entry hits
    search(mkreq(19'h12345, 1'b1, 10'd6), 0, 0, '0, lat, rs);
    chk("t2_lat", 128'(lat), 128'(3));
    chk("t2_miss", 128'(rs), 128'(0));
    e3g = e3;
    e3g.g = 1'b1;
    write_entry(3, e3g);
    search(mkreq(19'h12345, 1'b1, 10'd6), 0, 0, '0, lat, rs);
    chk("t2_glob", 128'(rs), 128'(hit_resp(3, 6'd12, e3g.p1)));

    // huge page: vppn[8] selects the odd half
    e7 = mk(19'h12200, 6'd21, 1'b1, 10'd0, 20'h66600, 20'h55500);
    write_entry(7, e7);
    search(mkreq(19'h123FF, 1'b0, 10'd0), 0, 0, '0, lat, rs);
    chk("t3_lat", 128'(lat), 128'(3));
    chk("t3_huge", 128'(rs), 128'(hit_resp(7, 6'd21, e7.p1)));

    // two hits: lowest index wins
    e2 = mk(19'h00AAA, 6'd12, 1'b1, 10'd0, 20'h22222, 20'h22223);
    e9 = mk(19'h00AAA, 6'd12, 1'b1, 10'd0, 20'h99999, 20'h9999A);
    write_entry(9, e9);
    write_entry(2, e2);
    search(mkreq(19'h00AAA, 1'b0, 10'd0), 0, 0, '0, lat, rs);
    chk("t4_prio", 128'(rs), 128'(hit_resp(2, 6'd12, e2.p0)));

    // invalidate-all with a same-cycle write
    e4 = mk(19'h00100, 6'd12, 1'b1, 10'd0, 20'h00001, 20'h00011);
    inv_all = 1'b1;
    write_entry(4, e4);
    inv_all = 1'b0;
    r_index = 5'd2;
    #1;
    chk("inv_e2", 128'(r_entry.e), 128'(0));
    r_index = 5'd4;
    #1;
    chk("inv_we4", 128'(r_entry), 128'(e4));
    search(mkreq(19'h00AAA, 1'b0, 10'd0), 0, 0, '0, lat, rs);
    chk("t4_inv_miss", 128'(rs), 128'(0));

    // write during CMP delays ready one cycle, shows new contents
    e4b = e4;
    e4b.p0.ppn = 20'h00002;
    search(mkreq(19'h00100, 1'b0, 10'd0), 1, 4, e4b, lat, rs);
    chk("t5_lat", 128'(lat), 128'(4));
    chk("t5_resp", 128'(rs), 128'(hit_resp(4, 6'd12, e4b.p0)));
    last_r = rs;

    // flush in RESP: no ready, idle next cycle, response held
    req   = mkreq(19'h00100, 1'b0, 10'd0);
    valid = 1'b1;
    @(negedge clk);
    chk("t6_busy_cmp", 128'(busy), 128'(1));
    @(negedge clk);
    flush = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("t6_busy_after", 128'(busy), 128'(0));
    chk("t6_resp_held", 128'(resp), 128'(last_r));
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (ready) seen++;
      @(negedge clk);
    end
    chk("t6_no_ready", 128'(seen), 128'(0));

    // flush with valid in IDLE blocks acceptance
    valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle", 128'(busy), 128'(0));

    // async reset mid-search
    exp_r = '0;
    valid = 1'b1;
    @(negedge clk);
    chk("rst_busy_cmp", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 128'(ready), 128'(0));
    chk("arst_resp", 128'(resp), 128'(exp_r));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_array", 128'(r_entry), 128'(0));
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    search(mkreq(19'h00100, 1'b0, 10'd0), 0, 0, '0, lat, rs);
    chk("post_rst_lat", 128'(lat), 128'(3));
    chk("post_rst_miss", 128'(rs), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
